// File: rtl/prm_edge_mask_scan.sv
// prm_edge_mask_scan
// ------------------
// Programmable sum-of-products collision checker for the PRM arm planner.
// A run-time loaded cube table (care mask, value, edge tag) is scanned
// LANES cubes per cycle against a latched obstacle code. Every matching
// cube sets the bit of its edge tag in an N_EDGE-bit blocked-edge mask.
// The mask is returned over a valid/ready handshake.
//
// Optional build macro: PRM_HIT_COUNT_EN
//   When defined, adds output r_hits, which counts the valid cubes that
//   matched during the scan. It is held together with r_mask.
//
// Ports
//   CLK, RST_n       clock, asynchronous active-low reset
//   cfg_we           cube write strobe (held by the master until cfg_ready)
//   cfg_clr          clear every cube valid bit (applied before a same-cycle write)
//   cfg_addr         cube index
//   cfg_care         care mask (1 = bit compared)
//   cfg_val          required value of the cared bits
//   cfg_edge         edge blocked by this cube (tags >= N_EDGE contribute nothing)
//   cfg_ready        config accepted this cycle (low while scanning)
//   q_valid/q_code   query handshake and obstacle code
//   q_ready          engine idle and able to take a query
//   r_valid/r_mask   result handshake and blocked-edge mask
//   r_ready          result consumed
//   r_hits           (PRM_HIT_COUNT_EN only) matched-cube count
module prm_edge_mask_scan #(
  parameter int IN_W      = 15,
  parameter int N_EDGE    = 8,
  parameter int NUM_CUBES = 32,
  parameter int LANES     = 4,
  parameter int EW        = $clog2(N_EDGE),
  parameter int CW        = $clog2(NUM_CUBES)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              cfg_we,
  input  logic              cfg_clr,
  input  logic [CW-1:0]     cfg_addr,
  input  logic [IN_W-1:0]   cfg_care,
  input  logic [IN_W-1:0]   cfg_val,
  input  logic [EW-1:0]     cfg_edge,
  output logic              cfg_ready,
  input  logic              q_valid,
  input  logic [IN_W-1:0]   q_code,
  output logic              q_ready,
  output logic              r_valid,
  output logic [N_EDGE-1:0] r_mask,
  input  logic              r_ready
`ifdef PRM_HIT_COUNT_EN
  ,
  output logic [CW:0]       r_hits
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the first cube of the final scan beat.
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CUBES - LANES);
  localparam logic [CW-1:0] STEP     = CW'(LANES);

  // Control state
  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [N_EDGE-1:0]   acc_q, acc_d;
  logic [CW:0]         hits_q, hits_d;
  logic [NUM_CUBES-1:0] vld_q, vld_d;

  // Data state (no reset: only meaningful when qualified by vld_q / state)
  logic [IN_W-1:0]     code_q, code_d;
  logic [IN_W-1:0]     care_q [NUM_CUBES];
  logic [IN_W-1:0]     care_d [NUM_CUBES];
  logic [IN_W-1:0]     val_q  [NUM_CUBES];
  logic [IN_W-1:0]     val_d  [NUM_CUBES];
  logic [EW-1:0]       edge_q [NUM_CUBES];
  logic [EW-1:0]       edge_d [NUM_CUBES];

  // Per-beat evaluation
  logic [CW-1:0]       lane_addr [LANES];
  logic [LANES-1:0]    lane_hit;
  logic [N_EDGE-1:0]   beat_mask;
  logic [CW:0]         beat_hits;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_addr[l] = idx_q + CW'(l);
    end
  end

  // A cube matches when it is valid and every cared bit of the code equals
  // the stored value. The edge one-hot is built only for tags below N_EDGE,
  // so out-of-range tags fall through without setting anything.
  always_comb begin
    lane_hit  = '0;
    beat_mask = '0;
    beat_hits = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_hit[l] = vld_q[lane_addr[l]] &&
                    (((code_q ^ val_q[lane_addr[l]]) & care_q[lane_addr[l]]) == '0);
      beat_hits = beat_hits + (CW+1)'(lane_hit[l]);
      for (int e = 0; e < N_EDGE; e++) begin
        if (lane_hit[l] && (edge_q[lane_addr[l]] == EW'(e))) begin
          beat_mask[e] = 1'b1;
        end
      end
    end
  end

  // Sequencer: next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    hits_d    = hits_q;
    code_d    = code_q;
    q_ready   = 1'b0;
    r_valid   = 1'b0;
    cfg_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        q_ready   = 1'b1;
        cfg_ready = 1'b1;
        if (q_valid) begin
          code_d  = q_code;
          acc_d   = '0;
          hits_d  = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d  = acc_q | beat_mask;
        hits_d = hits_q + beat_hits;
        idx_d  = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        r_valid   = 1'b1;
        cfg_ready = 1'b1;
        if (r_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cube table update. The clear is applied first so that a write in the
  // same cycle leaves its own cube valid. A query latched in the same cycle
  // starts scanning one cycle later and therefore sees the new entry.
  always_comb begin
    vld_d  = vld_q;
    care_d = care_q;
    val_d  = val_q;
    edge_d = edge_q;
    if (cfg_ready && cfg_clr) begin
      vld_d = '0;
    end
    if (cfg_ready && cfg_we) begin
      care_d[cfg_addr] = cfg_care;
      val_d[cfg_addr]  = cfg_val;
      edge_d[cfg_addr] = cfg_edge;
      vld_d[cfg_addr]  = 1'b1;
    end
  end

  // Control registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      hits_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      hits_q  <= hits_d;
      vld_q   <= vld_d;
    end
  end

  // Data registers
  always_ff @(posedge CLK) begin
    code_q <= code_d;
    care_q <= care_d;
    val_q  <= val_d;
    edge_q <= edge_d;
  end

  assign r_mask = acc_q;

`ifdef PRM_HIT_COUNT_EN
  assign r_hits = hits_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_scan.sv
module tb_prm_edge_mask_scan;

  localparam int IN_W      = 15;
  localparam int N_EDGE    = 8;
  localparam int NUM_CUBES = 32;
  localparam int LANES     = 4;
  // One extra tag bit so that out-of-range tags (e.g. 9) can be written.
  localparam int EW        = 4;
  localparam int CW        = 5;

  logic              CLK;
  logic              RST_n;
  logic              cfg_we;
  logic              cfg_clr;
  logic [CW-1:0]     cfg_addr;
  logic [IN_W-1:0]   cfg_care;
  logic [IN_W-1:0]   cfg_val;
  logic [EW-1:0]     cfg_edge;
  logic              cfg_ready;
  logic              q_valid;
  logic [IN_W-1:0]   q_code;
  logic              q_ready;
  logic              r_valid;
  logic [N_EDGE-1:0] r_mask;
  logic              r_ready;
`ifdef PRM_HIT_COUNT_EN
  logic [CW:0]       r_hits;
`endif

  int checks = 0;
  int errors = 0;

  prm_edge_mask_scan #(
    .IN_W(IN_W), .N_EDGE(N_EDGE), .NUM_CUBES(NUM_CUBES), .LANES(LANES),
    .EW(EW), .CW(CW)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_addr(cfg_addr),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_edge(cfg_edge),
    .cfg_ready(cfg_ready),
    .q_valid(q_valid), .q_code(q_code), .q_ready(q_ready),
    .r_valid(r_valid), .r_mask(r_mask), .r_ready(r_ready)
`ifdef PRM_HIT_COUNT_EN
    ,
    .r_hits(r_hits)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [CW-1:0] addr, input logic [IN_W-1:0] care,
                           input logic [IN_W-1:0] val, input logic [EW-1:0] edg,
                           input logic clr);
    @(negedge CLK);
    cfg_addr = addr;
    cfg_care = care;
    cfg_val  = val;
    cfg_edge = edg;
    cfg_we   = 1'b1;
    cfg_clr  = clr;
    for (int k = 0; k < 40 && !cfg_ready; k++) @(negedge CLK);
    @(posedge CLK);
    #1;
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
  endtask

  task automatic start_query(input string tag, input logic [IN_W-1:0] code);
    @(negedge CLK);
    chk({tag, "_qrdy_idle"}, 32'(q_ready), 32'd1);
    q_code  = code;
    q_valid = 1'b1;
    @(posedge CLK);
    #1;
    q_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [N_EDGE-1:0] exp_mask,
                             input int exp_hits);
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (n == 1) chk({tag, "_qrdy_scan"}, 32'(q_ready), 32'd0);
      if (r_valid) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_mask"}, 32'(r_mask), 32'(exp_mask));
`ifdef PRM_HIT_COUNT_EN
    chk({tag, "_hits"}, 32'(r_hits), 32'(exp_hits));
`else
    if (exp_hits < 0) $display("note: negative hit expectation in %s", tag);
`endif
  endtask

  task automatic release_result(input string tag);
    r_ready = 1'b1;
    @(posedge CLK);
    #1;
    r_ready = 1'b0;
    @(negedge CLK);
    chk({tag, "_rvld_drop"}, 32'(r_valid), 32'd0);
    chk({tag, "_qrdy_back"}, 32'(q_ready), 32'd1);
  endtask

  task automatic run_query(input string tag, input logic [IN_W-1:0] code,
                           input logic [N_EDGE-1:0] exp_mask, input int exp_hits);
    start_query(tag, code);
    wait_result(tag, exp_mask, exp_hits);
    release_result(tag);
  endtask

  initial begin
    RST_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_clr  = 1'b0;
    cfg_addr = '0;
    cfg_care = '0;
    cfg_val  = '0;
    cfg_edge = '0;
    q_valid  = 1'b0;
    q_code   = '0;
    r_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_qready", 32'(q_ready), 32'd1);
    chk("rst_cfgready", 32'(cfg_ready), 32'd1);
    chk("rst_rmask", 32'(r_mask), 32'd0);
    RST_n = 1'b1;

    // Empty table
    run_query("empty", 15'h0000, 8'h00, 0);

    // Full-care and single-bit cubes at both ends of the table
    cfg_write(5'd0,  15'h7FFF, 15'h1234, 4'd3, 1'b0);
    cfg_write(5'd31, 15'h0001, 15'h0001, 4'd7, 1'b0);
    run_query("q1235", 15'h1235, 8'h80, 1);
    run_query("q1234", 15'h1234, 8'h08, 1);
    run_query("q1233", 15'h1233, 8'h80, 1);

    // Always-matching cube, and an always-matching cube with tag 9 (ignored)
    cfg_write(5'd5, 15'h0000, 15'h0000, 4'd2, 1'b0);
    cfg_write(5'd6, 15'h0000, 15'h0000, 4'd9, 1'b0);
    run_query("tag9_a", 15'h1234, 8'h0C, 3);
    run_query("tag9_b", 15'h0000, 8'h04, 2);

    // Result held while r_ready is low; config accepted in DONE
    start_query("hold", 15'h0001);
    wait_result("hold", 8'h84, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_rvalid", 32'(r_valid), 32'd1);
      chk("hold_rmask", 32'(r_mask), 32'h84);
      chk("hold_qready", 32'(q_ready), 32'd0);
      chk("hold_cfgready", 32'(cfg_ready), 32'd1);
    end
    cfg_write(5'd10, 15'h0000, 15'h0000, 4'd0, 1'b0);
    @(negedge CLK);
    chk("hold_after_wr_rvalid", 32'(r_valid), 32'd1);
    chk("hold_after_wr_rmask", 32'(r_mask), 32'h84);
    release_result("hold");

    // Write presented during SCAN is held off until the scan ends
    start_query("scanwr", 15'h0001);
    cfg_addr = 5'd11;
    cfg_care = 15'h0000;
    cfg_val  = 15'h0000;
    cfg_edge = 4'd6;
    cfg_we   = 1'b1;
    @(negedge CLK);
    chk("scanwr_cfgready", 32'(cfg_ready), 32'd0);
    wait_result("scanwr", 8'h85, 4);
    release_result("scanwr");
    cfg_we = 1'b0;
    run_query("after_scanwr", 15'h0001, 8'hC5, 5);

    // Clear and write in the same cycle
    cfg_write(5'd2, 15'h0000, 15'h0000, 4'd1, 1'b1);
    run_query("clr_wr", 15'h1234, 8'h02, 1);

    // Reset in the middle of a scan
    start_query("midrst", 15'h0000);
    repeat (4) @(posedge CLK);
    #1;
    RST_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(r_valid), 32'd0);
    chk("midrst_qready", 32'(q_ready), 32'd1);
    chk("midrst_cfgready", 32'(cfg_ready), 32'd1);
    chk("midrst_rmask", 32'(r_mask), 32'd0);
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    run_query("post_rst", 15'h0000, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
